// File: rtl/reg_linear_inverse_pkg.sv
// Shared definitions for the linear price predictor and its inverse.
// Holds the default model coefficients, the bus widths, and the FSM state
// encoding. The predictor and this decoder use the same state encoding.
package reg_linear_inverse_pkg;

  // Bus widths of the price and size domains
  localparam int W_PRICE = 32;
  localparam int W_SIZE  = 16;

  // Default model coefficients: price = REG_THETA0 + REG_THETA1 * size
  localparam logic [W_PRICE-1:0] REG_THETA0 = 32'd10000;
  localparam logic [W_SIZE-1:0]  REG_THETA1 = 16'd5000;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Plain-vector copies of the state encoding, used where the state register
  // is kept as a raw logic vector
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/reg_linear_inverse_if.sv
// Handshake bus of the price->size decoder.
//   price/in_valid/in_ready     : request channel (price in)
//   size/remainder/underflow/
//   overflow/out_valid/out_ready: result channel (size out)
// The master modport is the requester/consumer side; the slave modport is
// the decoder itself.
interface reg_linear_inverse_if;
  import reg_linear_inverse_pkg::*;

  logic [W_PRICE-1:0] price;
  logic               in_valid;
  logic               in_ready;
  logic [W_SIZE-1:0]  size;
  logic [W_SIZE-1:0]  remainder;
  logic               underflow;
  logic               overflow;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output price, in_valid, out_ready,
    input  in_ready, size, remainder, underflow, overflow, out_valid
  );

  modport slave (
    input  price, in_valid, out_ready,
    output in_ready, size, remainder, underflow, overflow, out_valid
  );

endinterface

// File: rtl/reg_linear_inverse_div.sv
// Sequential restoring divider, 32-bit dividend by 16-bit divisor.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : load dividend/divisor and begin (ignored while busy)
//   dividend_i   : 32-bit unsigned dividend
//   divisor_i    : 16-bit unsigned divisor (nonzero)
//   busy_o       : iterations in progress
//   done_o       : high in the cycle whose closing edge performs the last step
//   quotient_o   : full 32-bit quotient, valid while done_o is high
//   rem_o        : final remainder, valid while done_o is high
// One quotient bit is produced per clock, MSB first, 32 steps after the load.
// quotient_o/rem_o expose the result of the step being taken so the caller can
// capture it on the same edge that completes the division.
module div32by16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [15:0] rem_o
);

  logic [31:0] dvd_q;
  logic [30:0] quot_q;
  logic [15:0] rem_q;
  logic [15:0] divisor_q;
  logic [4:0]  count_q;
  logic        busy_q;

  logic [16:0] remShift;
  logic        qBit;
  logic [15:0] remNext;
  logic [31:0] quotNext;

  // One restoring step. The shifted remainder needs 17 bits before the
  // compare; after a successful subtract the result is below the divisor, so
  // the low 16 bits of the difference are exact.
  always_comb begin
    remShift = {rem_q, dvd_q[31]};
    qBit     = (remShift >= {1'b0, divisor_q});
    remNext  = qBit ? (remShift[15:0] - divisor_q) : remShift[15:0];
    quotNext = {quot_q, qBit};
  end

  // Load on start, otherwise iterate while busy; count_q tracks steps left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else if (start_i && !busy_q) begin
      dvd_q     <= dividend_i;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= divisor_i;
      count_q   <= 5'd31;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      dvd_q   <= {dvd_q[30:0], 1'b0};
      quot_q  <= quotNext[30:0];
      rem_q   <= remNext;
      count_q <= count_q - 5'd1;
      if (count_q == 5'd0) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (count_q == 5'd0);
  assign quotient_o = quotNext;
  assign rem_o      = remNext;

endmodule

// File: rtl/reg_linear_inverse.sv
// Inverse of the linear price predictor: size = (price - THETA0) / THETA1.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any transaction
//   bus   : slave side of reg_linear_inverse_if
//           request : price, in_valid, in_ready
//           result  : size, remainder, underflow, overflow, out_valid, out_ready
// One transaction at a time: IDLE accepts a price, SUB removes the intercept
// (or flags underflow), DIV runs the 32-step divider, DONE holds the result
// until the consumer takes it. Quotients above 16 bits saturate size and set
// overflow. All results stay on the outputs until the next one is produced.
module reg_linear_inverse
  import reg_linear_inverse_pkg::*;
#(
  parameter logic [W_PRICE-1:0] THETA0 = REG_THETA0,
  parameter logic [W_SIZE-1:0]  THETA1 = REG_THETA1
) (
  input logic            clk,
  input logic            rst_n,
  reg_linear_inverse_if.slave bus
);

  // A zero slope has no inverse
  if (THETA1 == '0) begin : gen_bad_theta1
    $error("reg_linear_inverse: THETA1 must be nonzero");
  end

  logic [1:0]         state_q,    state_d;
  logic [W_PRICE-1:0] price_q,    price_d;
  logic               inReady_q,  inReady_d;
  logic               outValid_q, outValid_d;
  logic [W_SIZE-1:0]  size_q,     size_d;
  logic [W_SIZE-1:0]  rem_q,      rem_d;
  logic               under_q,    under_d;
  logic               over_q,     over_d;

  logic               divStart;
  logic               divBusy;
  logic               divDone;
  logic [31:0]        divQuot;
  logic [15:0]        divRem;
  logic [W_PRICE-1:0] divDividend;

  assign divDividend = price_q - THETA0;

  div32by16_seq u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (divStart),
    .dividend_i (divDividend),
    .divisor_i  (THETA1),
    .busy_o     (divBusy),
    .done_o     (divDone),
    .quotient_o (divQuot),
    .rem_o      (divRem)
  );

  // Transaction sequencing. in_ready comes up one edge after reset release
  // and is only ever high in IDLE, so nothing is accepted in the cycle a
  // result is consumed.
  always_comb begin
    state_d    = state_q;
    price_d    = price_q;
    inReady_d  = inReady_q;
    outValid_d = outValid_q;
    size_d     = size_q;
    rem_d      = rem_q;
    under_d    = under_q;
    over_d     = over_q;
    divStart   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!inReady_q) begin
          inReady_d = 1'b1;
        end else if (bus.in_valid) begin
          price_d   = bus.price;
          inReady_d = 1'b0;
          state_d   = ST_SUB;
        end
      end
      ST_SUB: begin
        if (price_q < THETA0) begin
          under_d    = 1'b1;
          over_d     = 1'b0;
          size_d     = '0;
          rem_d      = '0;
          outValid_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          divStart = 1'b1;
          state_d  = ST_DIV;
        end
      end
      ST_DIV: begin
        if (divBusy && divDone) begin
          under_d    = 1'b0;
          over_d     = |divQuot[31:16];
          size_d     = (|divQuot[31:16]) ? 16'hFFFF : divQuot[15:0];
          rem_d      = divRem;
          outValid_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: begin
        if (outValid_q && bus.out_ready) begin
          outValid_d = 1'b0;
          inReady_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      price_q    <= '0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      size_q     <= '0;
      rem_q      <= '0;
      under_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      price_q    <= price_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
      size_q     <= size_d;
      rem_q      <= rem_d;
      under_q    <= under_d;
      over_q     <= over_d;
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.size      = size_q;
  assign bus.remainder = rem_q;
  assign bus.underflow = under_q;
  assign bus.overflow  = over_q;

endmodule
